hidden_writeback: RTL and testbench

Output end of the LSTM datapath: captures the hidden-state elements produced by the PE array for one timestep into a local buffer. It then writes them back to main memory and replays them, with addresses, into the input buffer's cell-load port as the recurrent operand for the next timestep. It ends each timestep by pulsing start_load_input so the input side fetches the next feature vector.

---
 rtl/hidden_wb_pkg.sv | 24 ++
 rtl/hidden_wb_buf.sv | 47 ++++
 rtl/hidden_writeback.sv | 176 +++++++++++++++++
 tb/tb_hidden_writeback.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hidden_wb_pkg.sv
// hidden_wb_pkg
//   Shared types and constants for the hidden-state writeback block.
//   - state_e      : writeback FSM state encoding (3 bits)
//   - HW_*         : default geometry used as parameter defaults by the top
//   - HW_LAST_IDX  : last element index (HIDDEN-1) for the default geometry
package hidden_wb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    WRITE_MEM = 3'd2,
    CELL_REQ  = 3'd3,
    FEED      = 3'd4,
    FINISH    = 3'd5
  } state_e;

  localparam int HW_FEATURE_BITS = 4;
  localparam int HW_ELEMENT_BITS = 8;
  localparam int HW_ADDR_BITS    = 8;
  localparam int HW_HIDDEN       = 4'b1000;

  localparam logic [HW_FEATURE_BITS-1:0] HW_LAST_IDX = HW_FEATURE_BITS'(HW_HIDDEN - 1);

endpackage

// File: rtl/hidden_wb_buf.sv
// hidden_wb_buf
//   DEPTH x DATA_BITS register file holding one timestep of hidden elements.
//   Ports:
//     clk_i    : clock, rising edge
//     we_i     : write enable
//     waddr_i  : write index
//     wdata_i  : write data
//     raddr_i  : read index (combinational read)
//     rdata_o  : read data, 0 for an index outside 0..DEPTH-1
//   Contents are never reset; they are only meaningful after being written.
module hidden_wb_buf #(
  parameter int DEPTH     = 8,
  parameter int IDX_BITS  = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IDX_BITS-1:0]  waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic [IDX_BITS-1:0]  raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DEPTH-1:0][DATA_BITS-1:0] words;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_BITS-1:0] entry_q;

    always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i == IDX_BITS'(gi))) begin
        entry_q <= wdata_i;
      end
    end

    assign words[gi] = entry_q;
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_i == IDX_BITS'(i)) begin
        rdata_o = words[i];
      end
    end
  end

endmodule

// File: rtl/hidden_writeback.sv
// hidden_writeback
//   Captures HIDDEN elements from the PE array, writes them to main memory
//   at base_address+idx, replays them into the input buffer's cell-load port,
//   then pulses start_load_input/done.
//   Optional build macro: HIDDEN_WB_DROP_FLAG_EN adds the sticky drop_err
//   output, flagging PE beats that arrive while not collecting.
//   Ports:
//     sys_clk, reset             : clock and asynchronous active-high reset
//     start, base_address        : arm one timestep, memory base for element 0
//     pe_valid, pe_data_out      : element stream from the PE array
//     main_mem_busy              : memory write stall
//     main_mem_we/address/data_in: memory write port
//     load_cell                  : one-cycle pulse ahead of the cell stream
//     cell_out_data_in, hidden_address : recurrent element and its index
//     start_load_input, done     : end-of-timestep pulses
//     busy                       : high whenever not IDLE
//     drop_err                   : (optional) sticky dropped-beat flag
module hidden_writeback
  import hidden_wb_pkg::*;
#(
  parameter int FEATURE_BITS = HW_FEATURE_BITS,
  parameter int ELEMENT_BITS = HW_ELEMENT_BITS,
  parameter int ADDR_BITS    = HW_ADDR_BITS,
  parameter int HIDDEN       = HW_HIDDEN
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_BITS-1:0]    base_address,
  input  logic                    pe_valid,
  input  logic [ELEMENT_BITS-1:0] pe_data_out,
  input  logic                    main_mem_busy,
  output logic                    main_mem_we,
  output logic [ADDR_BITS-1:0]    main_mem_address,
  output logic [ELEMENT_BITS-1:0] main_mem_data_in,
  output logic                    load_cell,
  output logic [ELEMENT_BITS-1:0] cell_out_data_in,
  output logic [FEATURE_BITS-1:0] hidden_address,
  output logic                    start_load_input,
  output logic                    busy,
`ifdef HIDDEN_WB_DROP_FLAG_EN
  output logic                    drop_err,
`endif
  output logic                    done
);

  localparam logic [FEATURE_BITS-1:0] LAST_IDX = FEATURE_BITS'(HIDDEN - 1);

  state_e                  state_q, state_d;
  logic [FEATURE_BITS-1:0] idx_q, idx_d;
  logic [ADDR_BITS-1:0]    base_q, base_d;
  logic                    buf_we;
  logic [ELEMENT_BITS-1:0] rd_data;
  logic                    idx_last;

  assign idx_last = (idx_q == LAST_IDX);

  // Single index register serves capture, writeback and feed; each phase
  // restarts it at 0, so one read port on the buffer is enough.
  hidden_wb_buf #(
    .DEPTH    (HIDDEN),
    .IDX_BITS (FEATURE_BITS),
    .DATA_BITS(ELEMENT_BITS)
  ) u_buf (
    .clk_i  (sys_clk),
    .we_i   (buf_we),
    .waddr_i(idx_q),
    .wdata_i(pe_data_out),
    .raddr_i(idx_q),
    .rdata_o(rd_data)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    buf_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_address;
          idx_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (pe_valid) begin
          buf_we = 1'b1;
          if (idx_last) begin
            idx_d   = '0;
            state_d = WRITE_MEM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WRITE_MEM: begin
        // The stall only gates the index; address/data follow idx_q and so
        // stay put while main_mem_busy is high.
        if (!main_mem_busy) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = CELL_REQ;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CELL_REQ: begin
        state_d = FEED;
      end
      FEED: begin
        if (idx_last) begin
          idx_d   = '0;
          state_d = FINISH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign main_mem_we      = (state_q == WRITE_MEM);
  assign main_mem_address = main_mem_we ? (base_q + ADDR_BITS'(idx_q)) : '0;
  assign main_mem_data_in = main_mem_we ? rd_data : '0;
  assign load_cell        = (state_q == CELL_REQ);
  assign cell_out_data_in = (state_q == FEED) ? rd_data : '0;
  assign hidden_address   = (state_q == FEED) ? idx_q : '0;
  assign start_load_input = (state_q == FINISH);
  assign done             = (state_q == FINISH);
  assign busy             = (state_q != IDLE);

`ifdef HIDDEN_WB_DROP_FLAG_EN
  logic drop_q, drop_d;

  // Accepting a start clears the flag even if a beat arrives in that cycle.
  always_comb begin
    drop_d = drop_q;
    if ((state_q == IDLE) && start) begin
      drop_d = 1'b0;
    end else if (pe_valid && (state_q != COLLECT)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_err = drop_q;
`endif

endmodule

// File: tb/tb_hidden_writeback.sv
module tb_hidden_writeback;

  localparam int H = 8;

  logic       sys_clk = 1'b0;
  logic       reset, start, pe_valid, main_mem_busy;
  logic [7:0] base_address, pe_data_out;
  logic       main_mem_we, load_cell, start_load_input, busy, done;
  logic [7:0] main_mem_address, main_mem_data_in, cell_out_data_in;
  logic [3:0] hidden_address;
`ifdef HIDDEN_WB_DROP_FLAG_EN
  logic       drop_err;
`endif

  hidden_writeback dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .start           (start),
    .base_address    (base_address),
    .pe_valid        (pe_valid),
    .pe_data_out     (pe_data_out),
    .main_mem_busy   (main_mem_busy),
    .main_mem_we     (main_mem_we),
    .main_mem_address(main_mem_address),
    .main_mem_data_in(main_mem_data_in),
    .load_cell       (load_cell),
    .cell_out_data_in(cell_out_data_in),
    .hidden_address  (hidden_address),
    .start_load_input(start_load_input),
    .busy            (busy),
`ifdef HIDDEN_WB_DROP_FLAG_EN
    .drop_err        (drop_err),
`endif
    .done            (done)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int vec = 0;
  int err = 0;

  // Observed-event capture (what the DUT did), compared later against the
  // expectations each test derives from its own stimulus.
  logic [15:0] wr_q[$];
  logic [7:0]  we_addr_q[$];
  logic [11:0] fd_q[$];
  int          lc_q[$];
  int          done_q[$];
  int          we_first, hold_viol, idle_nz, pulse_mis, feed_left = 0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_addr, prev_data;

  logic [7:0]  exp_d [H];
  int          last_beat, stalls;

  always @(negedge sys_clk) begin
    if (reset) begin
      prev_hold = 1'b0;
      feed_left = 0;
    end else begin
      if (prev_hold && (main_mem_we !== 1'b1 || main_mem_address !== prev_addr ||
                        main_mem_data_in !== prev_data))
        hold_viol++;
      prev_hold = main_mem_we && main_mem_busy;
      prev_addr = main_mem_address;
      prev_data = main_mem_data_in;
      if (main_mem_we) begin
        we_addr_q.push_back(main_mem_address);
        if (we_first < 0) we_first = cyc;
        if (!main_mem_busy) wr_q.push_back({main_mem_address, main_mem_data_in});
      end
      if (feed_left > 0) begin
        fd_q.push_back({hidden_address, cell_out_data_in});
        feed_left--;
      end else if (cell_out_data_in !== 8'h00 || hidden_address !== 4'h0) begin
        idle_nz++;
      end
      if (load_cell) begin
        lc_q.push_back(cyc);
        feed_left = H;
      end
      if (done) done_q.push_back(cyc);
      if (done !== start_load_input) pulse_mis++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_caps();
    wr_q.delete(); we_addr_q.delete(); fd_q.delete(); lc_q.delete(); done_q.delete();
    we_first = -1; hold_viol = 0; idle_nz = 0; pulse_mis = 0;
  endtask

  // One timestep of stimulus. A junk beat rides on the start cycle (must be
  // ignored). Busy is driven from the bench's own count of completed writes.
  task automatic drive_step(input logic [7:0] base, input bit gap, input int sidx,
                            input int slen, input bit rnd, input bit inject);
    int comp;
    bit b;
    clear_caps();
    start = 1'b1; base_address = base; pe_valid = 1'b1; pe_data_out = 8'hA5;
    tick();
    start = 1'b0;
    for (int i = 0; i < H; i++) begin
      if (gap) begin
        pe_valid = 1'b0; pe_data_out = 8'($urandom);
        tick();
      end
      pe_valid = 1'b1; pe_data_out = exp_d[i]; last_beat = cyc;
      tick();
    end
    pe_valid = 1'b0;
    stalls = 0; comp = 0;
    while (comp < H) begin
      if (rnd) b = ($urandom_range(0, 2) == 0) && (stalls < 6);
      else     b = (comp == sidx) && (stalls < slen);
      main_mem_busy = b;
      if (b) stalls++; else comp++;
      tick();
    end
    main_mem_busy = 1'b0;
    for (int k = 0; k < 30 && done_q.size() == 0; k++) begin
      if (inject && k == 3) begin
        start = 1'b1; pe_valid = 1'b1; base_address = ~base; pe_data_out = 8'h5A;
      end else begin
        start = 1'b0; pe_valid = 1'b0;
      end
      tick();
    end
    start = 1'b0; pe_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_timestep(input string name, input logic [7:0] base, input bit gap,
                               input int sidx, input int slen, input bit rnd,
                               input bit inject, input bit fixed);
    logic [15:0] wgot, wexp;
    logic [11:0] fgot, fexp;
    for (int i = 0; i < H; i++) exp_d[i] = fixed ? 8'(8'h11 + i) : 8'($urandom);
    drive_step(base, gap, sidx, slen, rnd, inject);

    vec++;
    if (wr_q.size() !== H) begin
      err++; $display("FAIL %s.write_count: got %0d want %0d", name, wr_q.size(), H);
    end
    for (int i = 0; i < H; i++) begin
      wexp = {8'(base + 8'(i)), exp_d[i]};
      wgot = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
      vec++;
      if (wgot !== wexp) begin
        err++; $display("FAIL %s.write[%0d]: got addr/data %h want %h", name, i, wgot, wexp);
      end
    end
    vec++;
    if (we_addr_q.size() !== H + stalls) begin
      err++; $display("FAIL %s.we_cycles: got %0d want %0d", name, we_addr_q.size(), H + stalls);
    end
    vec++;
    if (we_first !== last_beat + 1) begin
      err++; $display("FAIL %s.write_start: got cycle %0d want %0d", name, we_first, last_beat + 1);
    end
    vec++;
    if (lc_q.size() !== 1 || lc_q[0] !== last_beat + 9 + stalls) begin
      err++; $display("FAIL %s.load_cell: got %0d pulses first at %0d want 1 at %0d", name,
                      lc_q.size(), (lc_q.size() > 0) ? lc_q[0] : -1, last_beat + 9 + stalls);
    end
    for (int i = 0; i < H; i++) begin
      fexp = {4'(i), exp_d[i]};
      fgot = (i < fd_q.size()) ? fd_q[i] : 12'hxxx;
      vec++;
      if (fgot !== fexp) begin
        err++; $display("FAIL %s.feed[%0d]: got idx/data %h want %h", name, i, fgot, fexp);
      end
    end
    vec++;
    if (done_q.size() !== 1 || done_q[0] !== last_beat + 18 + stalls) begin
      err++; $display("FAIL %s.done: got %0d pulses first at %0d want 1 at %0d", name,
                      done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, last_beat + 18 + stalls);
    end
    vec++;
    if (hold_viol !== 0 || idle_nz !== 0 || pulse_mis !== 0) begin
      err++; $display("FAIL %s.protocol: got hold=%0d idle_nonzero=%0d pulse_mismatch=%0d want 0/0/0",
                      name, hold_viol, idle_nz, pulse_mis);
    end
    vec++;
    if (busy !== 1'b0) begin
      err++; $display("FAIL %s.idle_after: got busy=%b want 0", name, busy);
    end
    $display("step %s base=%h gap=%0d stalls=%0d last_beat=%0d", name, base, gap, stalls, last_beat);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_address = 8'h00; pe_valid = 1'b0;
    pe_data_out = 8'h00; main_mem_busy = 1'b0;
    repeat (2) tick();
    vec++;
    if ({main_mem_we, main_mem_address, main_mem_data_in, load_cell, cell_out_data_in,
         hidden_address, start_load_input, busy, done} !== 33'd0) begin
      err++; $display("FAIL reset.outputs: got nonzero outputs want all 0");
    end
`ifdef HIDDEN_WB_DROP_FLAG_EN
    vec++;
    if (drop_err !== 1'b0) begin
      err++; $display("FAIL reset.drop_err: got %b want 0", drop_err);
    end
`endif
    reset = 1'b0;
    tick();
    $display("reset check done");
  endtask

  task automatic test_stall();
    int n42 = 0;
    test_timestep("stall", 8'h40, 1'b0, 2, 3, 1'b0, 1'b0, 1'b1);
    foreach (we_addr_q[i]) if (we_addr_q[i] == 8'h42) n42++;
    vec++;
    if (n42 !== 4) begin
      err++; $display("FAIL stall.held_42: got %0d cycles want 4", n42);
    end
  endtask

  task automatic test_wrap();
    test_timestep("wrap", 8'hFE, 1'b0, -1, 0, 1'b0, 1'b0, 0);
    vec++;
    if (wr_q.size() < 3 || wr_q[2][15:8] !== 8'h00) begin
      err++; $display("FAIL wrap.third_addr: got %h want 00",
                      (wr_q.size() >= 3) ? wr_q[2][15:8] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid();
    clear_caps();
    start = 1'b1; base_address = 8'h30; pe_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < H; i++) begin
      pe_valid = 1'b1; pe_data_out = 8'($urandom);
      tick();
    end
    pe_valid = 1'b0; main_mem_busy = 1'b0;
    repeat (3) tick();
    vec++;
    if (main_mem_we !== 1'b1 || main_mem_address !== 8'h33) begin
      err++; $display("FAIL reset_mid.pre: got we=%b addr=%h want 1/33", main_mem_we, main_mem_address);
    end
    reset = 1'b1;
    #1;
    vec++;
    if ({main_mem_we, main_mem_address, main_mem_data_in, load_cell, cell_out_data_in,
         hidden_address, start_load_input, busy, done} !== 33'd0) begin
      err++; $display("FAIL reset_mid.outputs: got nonzero outputs want all 0");
    end
    tick();
    reset = 1'b0;
    tick();
    $display("reset mid WRITE_MEM applied");
    test_timestep("after_reset", 8'h50, 1'b0, -1, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_ignored();
    test_timestep("ignored", 8'h60, 1'b0, -1, 0, 1'b0, 1'b1, 0);
`ifdef HIDDEN_WB_DROP_FLAG_EN
    vec++;
    if (drop_err !== 1'b1) begin
      err++; $display("FAIL ignored.drop_set: got %b want 1", drop_err);
    end
    test_timestep("drop_clear", 8'h70, 1'b1, -1, 0, 1'b0, 1'b0, 0);
    vec++;
    if (drop_err !== 1'b0) begin
      err++; $display("FAIL ignored.drop_clear: got %b want 0", drop_err);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      test_timestep("random", 8'($urandom), 1'($urandom), -1, 0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_timestep("basic", 8'h40, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1);
    test_timestep("gapped", 8'h40, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1);
    test_stall();
    test_wrap();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
